// File: rtl/gbf_load_seq.sv
// Global-buffer load sequencer: steers one valid/ready word stream into NUM_CH
// buffers, either channel by channel or broadcast to every enabled channel.
module gbf_load_seq #(
    parameter  int NUM_CH     = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 12,
    parameter  int LEN_WIDTH  = 13,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_wr,
    input  logic [CH_W-1:0]                cfg_ch,
    input  logic [ADDR_WIDTH-1:0]          cfg_base,
    input  logic [LEN_WIDTH-1:0]           cfg_len,
    input  logic                           cfg_en,
    input  logic                           start,
    input  logic                           bcast,
    input  logic                           abort,
    output logic                           busy,
    output logic                           done,
    input  logic                           in_vld,
    output logic                           in_rdy,
    input  logic [DATA_WIDTH-1:0]          in_dat,
    input  logic [NUM_CH-1:0]              gbf_val,
    output logic [NUM_CH-1:0]              gbf_enwr,
    output logic [NUM_CH*ADDR_WIDTH-1:0]   gbf_addrwr,
    output logic [NUM_CH*DATA_WIDTH-1:0]   gbf_datwr
);

    typedef enum logic [1:0] {S_IDLE, S_SEL, S_LOAD, S_FIN} state_t;

    state_t                 state_q;
    logic [ADDR_WIDTH-1:0]  base_q [NUM_CH];
    logic [LEN_WIDTH-1:0]   len_cfg_q [NUM_CH];
    logic [NUM_CH-1:0]      en_q;
    logic [CH_W:0]          cur_q;      // one spare bit so cur can step past the last channel
    logic [LEN_WIDTH-1:0]   cnt_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic                   bcast_q;
    logic [NUM_CH-1:0]      enwr_q;

    logic [CH_W-1:0]        cur_ch;
    logic [NUM_CH-1:0]      qual;
    logic [NUM_CH-1:0]      wr_sel;
    logic                   sel_found, nxt_found, bc_found;
    logic [CH_W-1:0]        sel_idx, bc_idx;
    logic                   all_rdy, accept, last_word;

    assign cur_ch    = cur_q[CH_W-1:0];
    assign all_rdy   = &(gbf_val | ~en_q);
    assign in_rdy    = (state_q == S_LOAD) && !abort && (bcast_q ? all_rdy : gbf_val[cur_ch]);
    assign accept    = in_vld && in_rdy;
    assign last_word = (cnt_q == len_q - LEN_WIDTH'(1));
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN);
    assign gbf_enwr  = enwr_q;

    // Lowest qualifying channel at/after cur, whether one exists strictly after
    // cur, and the lowest enabled channel (broadcast length source).
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        nxt_found = 1'b0;
        bc_found  = 1'b0;
        bc_idx    = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (qual[k] && ((CH_W+1)'(k) >= cur_q)) begin
                sel_found = 1'b1;
                sel_idx   = CH_W'(k);
            end
            if (qual[k] && ((CH_W+1)'(k) > cur_q)) begin
                nxt_found = 1'b1;
            end
            if (en_q[k]) begin
                bc_found = 1'b1;
                bc_idx   = CH_W'(k);
            end
        end
    end

    // Last word of the final channel jumps straight to FIN so done lines up
    // with the final write instead of trailing it by a SEL bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            bcast_q <= 1'b0;
            enwr_q  <= '0;
            en_q    <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                base_q[k]    <= '0;
                len_cfg_q[k] <= '0;
            end
        end else begin
            enwr_q <= wr_sel;
            if (cfg_wr && state_q == S_IDLE) begin
                base_q[cfg_ch]    <= cfg_base;
                len_cfg_q[cfg_ch] <= cfg_len;
                en_q[cfg_ch]      <= cfg_en;
            end
            if (abort) begin
                state_q <= S_IDLE;
                cur_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q <= S_SEL;
                            bcast_q <= bcast;
                            cur_q   <= '0;
                        end
                    end
                    S_SEL: begin
                        cnt_q <= '0;
                        if (bcast_q) begin
                            if (bc_found && len_cfg_q[bc_idx] != '0) begin
                                len_q   <= len_cfg_q[bc_idx];
                                state_q <= S_LOAD;
                            end else begin
                                state_q <= S_FIN;
                            end
                        end else if (sel_found) begin
                            cur_q   <= {1'b0, sel_idx};
                            len_q   <= len_cfg_q[sel_idx];
                            state_q <= S_LOAD;
                        end else begin
                            state_q <= S_FIN;
                        end
                    end
                    S_LOAD: begin
                        if (accept) begin
                            cnt_q <= cnt_q + LEN_WIDTH'(1);
                            if (last_word) begin
                                if (!bcast_q && nxt_found) begin
                                    cur_q   <= cur_q + (CH_W+1)'(1);
                                    state_q <= S_SEL;
                                end else begin
                                    state_q <= S_FIN;
                                end
                            end
                        end
                    end
                    S_FIN: begin
                        state_q <= S_IDLE;
                        cur_q   <= '0;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [ADDR_WIDTH-1:0] addr_q;
            logic [DATA_WIDTH-1:0] dat_q;

            assign qual[gi]   = en_q[gi] && (len_cfg_q[gi] != '0);
            assign wr_sel[gi] = accept && (bcast_q ? en_q[gi] : (cur_ch == CH_W'(gi)));

            // Address wraps modulo the buffer size; idle channels hold their last values.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    addr_q <= '0;
                    dat_q  <= '0;
                end else if (wr_sel[gi]) begin
                    addr_q <= base_q[gi] + ADDR_WIDTH'(cnt_q);
                    dat_q  <= in_dat;
                end
            end

            assign gbf_addrwr[gi*ADDR_WIDTH +: ADDR_WIDTH] = addr_q;
            assign gbf_datwr[gi*DATA_WIDTH +: DATA_WIDTH]  = dat_q;
        end
    endgenerate

endmodule

// File: tb/tb_gbf_load_seq.sv
// Randomised scoreboard bench for gbf_load_seq: a pass-level model predicts every
// buffer write; a negedge monitor pops and compares whatever the DUT writes.
module tb_gbf_load_seq;
    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int AW  = 12;
    localparam int LW  = 13;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_wr, cfg_en, start, bcast, abort, in_vld;
    logic [1:0]        cfg_ch;
    logic [AW-1:0]     cfg_base;
    logic [LW-1:0]     cfg_len;
    logic [DW-1:0]     in_dat;
    logic [NCH-1:0]    gbf_val;
    logic              busy, done, in_rdy;
    logic [NCH-1:0]    gbf_enwr;
    logic [NCH*AW-1:0] gbf_addrwr;
    logic [NCH*DW-1:0] gbf_datwr;

    gbf_load_seq #(.NUM_CH(NCH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_base(cfg_base),
        .cfg_len(cfg_len), .cfg_en(cfg_en), .start(start), .bcast(bcast), .abort(abort),
        .busy(busy), .done(done), .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
        .gbf_val(gbf_val), .gbf_enwr(gbf_enwr), .gbf_addrwr(gbf_addrwr), .gbf_datwr(gbf_datwr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            ch;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
        bit            last;
    } wr_t;

    wr_t           exp_q[$];
    logic [DW-1:0] words[$];
    int            total = 0, bad = 0, done_cnt = 0, done_cyc = 0;
    int            m_base[NCH], m_len[NCH];
    bit            m_en[NCH];

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    // Scoreboard monitor: every write must match the next predicted one, in channel order.
    always @(negedge clk) begin
        if (!rst) begin
            bit  any;
            bit  lst;
            wr_t e;
            any = 1'b0;
            lst = 1'b0;
            for (int k = 0; k < NCH; k++) begin
                if (gbf_enwr[k]) begin
                    any = 1'b1;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write: ch=%0d addr=%03h dat=%08h, none required",
                                 k, gbf_addrwr[k*AW +: AW], gbf_datwr[k*DW +: DW]);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_ch", 64'(k), 64'(e.ch));
                        check("wr_addr", 64'(gbf_addrwr[k*AW +: AW]), 64'(e.addr));
                        check("wr_dat", 64'(gbf_datwr[k*DW +: DW]), 64'(e.dat));
                        lst = e.last;
                    end
                end
            end
            if (any) check("done_with_last", 64'(done), 64'(lst));
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic cfg(input int ch, input int base, input int len, input bit en);
        @(posedge clk); #1;
        cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_base = AW'(base); cfg_len = LW'(len); cfg_en = en;
        @(posedge clk); #1;
        cfg_wr = 1'b0;
        m_base[ch] = base; m_len[ch] = len; m_en[ch] = en;
    endtask

    // Reference model: list every write a full pass must make, in stream order.
    task automatic build_model(input bit bc, output int n);
        int            lo;
        logic [DW-1:0] w;
        exp_q.delete();
        words.delete();
        if (!bc) begin
            for (int ch = 0; ch < NCH; ch++)
                if (m_en[ch] && m_len[ch] != 0)
                    for (int i = 0; i < m_len[ch]; i++) begin
                        w = $urandom;
                        words.push_back(w);
                        exp_q.push_back('{ch, AW'((m_base[ch] + i) % 4096), w, 1'b0});
                    end
        end else begin
            lo = -1;
            for (int ch = NCH - 1; ch >= 0; ch--) if (m_en[ch]) lo = ch;
            if (lo >= 0)
                for (int i = 0; i < m_len[lo]; i++) begin
                    w = $urandom;
                    words.push_back(w);
                    for (int ch = 0; ch < NCH; ch++)
                        if (m_en[ch]) exp_q.push_back('{ch, AW'((m_base[ch] + i) % 4096), w, 1'b0});
                end
        end
        if (exp_q.size() > 0) exp_q[exp_q.size() - 1].last = 1'b1;
        n = words.size();
    endtask

    // kill_kind: 0 run to done, 1 abort after kill_after words, 2 reset after kill_after words.
    task automatic run_pass(input bit bc, input int kill_kind, input int kill_after,
                            input int gap_ch, input int gap_after, input int gap_len,
                            input bit rnd, input bit lock_probe);
        int n, idx, budget, gap_left, start_cyc, base_done;
        bit acc, in_gap, gap_done;
        build_model(bc, n);
        base_done = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; bcast = bc; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0; bcast = 1'b0;
        if (lock_probe) begin
            cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_base = 12'hABC; cfg_len = 13'd1; cfg_en = 1'b1;
        end
        @(negedge clk);
        check("busy_rise", 64'(busy), 64'd1);
        @(posedge clk); #1;
        cfg_wr = 1'b0;
        idx = 0; budget = 500; gap_left = gap_len; gap_done = 1'b0;
        while (idx < n && budget > 0) begin
            if (kill_kind != 0 && idx == kill_after) break;
            budget--;
            in_gap  = !gap_done && gap_len > 0 && idx == gap_after;
            gbf_val = in_gap ? ~(4'b1 << gap_ch) : (rnd ? (4'($urandom) | 4'($urandom)) : 4'hF);
            in_vld  = in_gap ? 1'b1 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            in_dat  = words[idx];
            @(negedge clk);
            acc = in_vld && in_rdy;
            if (in_gap) check("gap_rdy", 64'(in_rdy), 64'd0);
            @(posedge clk); #1;
            if (acc) idx++;
            if (in_gap) begin
                gap_left--;
                if (gap_left == 0) gap_done = 1'b1;
            end
        end
        in_vld = 1'b0; gbf_val = 4'hF;
        if (budget == 0) begin
            total++; bad++;
            $display("FAIL stream_timeout: accepted %0d required %0d", idx, n);
        end
        if (kill_kind == 1) begin
            abort = 1'b1; in_vld = 1'b1; in_dat = words[idx];
            @(negedge clk);
            check("abort_rdy", 64'(in_rdy), 64'd0);
            @(posedge clk); #1;
            abort = 1'b0; in_vld = 1'b0;
            @(negedge clk);
            check("abort_idle", 64'(busy), 64'd0);
            repeat (3) @(negedge clk);
            #1;
            check("abort_writes_left", 64'(exp_q.size()), 64'(n - kill_after));
            check("abort_no_done", 64'(done_cnt), 64'(base_done));
            exp_q.delete();
        end else if (kill_kind == 2) begin
            #2 rst = 1'b1;
            #1;
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_in_rdy", 64'(in_rdy), 64'd0);
            check("rst_enwr", 64'(gbf_enwr), 64'd0);
            check("rst_addr", 64'(gbf_addrwr), 64'd0);
            check("rst_dat", 64'(gbf_datwr[63:0]), 64'd0);
            exp_q.delete();
            for (int ch = 0; ch < NCH; ch++) begin
                m_base[ch] = 0; m_len[ch] = 0; m_en[ch] = 1'b0;
            end
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            check("rst_release_idle", 64'(busy), 64'd0);
            repeat (2) @(negedge clk);
        end else begin
            budget = 50;
            while (done_cnt == base_done && budget > 0) begin
                @(negedge clk); #1;
                budget--;
            end
            if (budget == 0) begin
                total++; bad++;
                $display("FAIL done_timeout: no done pulse, pending writes %0d", exp_q.size());
            end else begin
                if (n == 0) check("empty_done_latency", 64'(done_cyc - start_cyc), 64'd2);
                @(negedge clk);
                check("busy_fall", 64'(busy), 64'd0);
            end
            check("all_writes_seen", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        $display("pass bc=%0d kill=%0d words=%0d done_cnt=%0d total=%0d", bc, kill_kind, n, done_cnt, total);
    endtask

    initial begin
        rst = 1'b1; cfg_wr = 1'b0; cfg_ch = '0; cfg_base = '0; cfg_len = '0; cfg_en = 1'b0;
        start = 1'b0; bcast = 1'b0; abort = 1'b0; in_vld = 1'b0; in_dat = '0; gbf_val = 4'hF;
        for (int ch = 0; ch < NCH; ch++) begin
            m_base[ch] = 0; m_len[ch] = 0; m_en[ch] = 1'b0;
        end
        #2;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_in_rdy", 64'(in_rdy), 64'd0);
        check("reset_enwr", 64'(gbf_enwr), 64'd0);
        check("reset_addr", 64'(gbf_addrwr), 64'd0);
        check("reset_dat", 64'(gbf_datwr[63:0]), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // start together with abort must stay idle
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("abort_start_idle", 64'(busy), 64'd0);

        run_pass(1'b0, 0, 0, 0, 99, 0, 1'b0, 1'b0);          // empty pass

        cfg(0, 12'h000, 3, 1'b1);
        cfg(1, 12'h080, 4, 1'b0);
        cfg(2, 12'h100, 2, 1'b1);
        cfg(3, 12'h180, 0, 1'b1);
        run_pass(1'b0, 0, 0, 0, 99, 0, 1'b0, 1'b0);          // sequential

        cfg(0, 12'hFFE, 4, 1'b1);
        cfg(2, 12'h100, 0, 1'b0);
        cfg(3, 12'h180, 0, 1'b0);
        run_pass(1'b0, 0, 0, 0, 99, 0, 1'b0, 1'b0);          // wrap

        cfg(0, 12'h020, 6, 1'b1);
        run_pass(1'b0, 0, 0, 0, 2, 3, 1'b1, 1'b1);           // backpressure + cfg while busy
        run_pass(1'b0, 0, 0, 0, 99, 0, 1'b0, 1'b0);          // old config still in force

        cfg(0, 12'h010, 2, 1'b1);
        cfg(1, 12'h200, 5, 1'b1);
        cfg(2, 12'h040, 1, 1'b1);
        cfg(3, 12'h300, 3, 1'b0);
        run_pass(1'b1, 0, 0, 2, 0, 2, 1'b0, 1'b0);           // broadcast with ch2 stall

        cfg(0, 12'h300, 5, 1'b1);
        cfg(1, 12'h200, 5, 1'b0);
        cfg(2, 12'h040, 1, 1'b0);
        run_pass(1'b0, 1, 2, 0, 99, 0, 1'b0, 1'b0);          // abort after 2 words
        run_pass(1'b0, 0, 0, 0, 99, 0, 1'b0, 1'b0);          // restart from cnt=0

        for (int r = 0; r < 10; r++) begin
            for (int ch = 0; ch < NCH; ch++)
                cfg(ch, int'($urandom_range(0, 4095)), int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
            run_pass(1'($urandom_range(0, 1)), 0, 0, 0, 99, 0, 1'b1, 1'b0);
        end

        cfg(0, 12'h000, 0, 1'b0);
        cfg(1, 12'h050, 6, 1'b1);
        cfg(2, 12'h000, 0, 1'b0);
        cfg(3, 12'h000, 0, 1'b0);
        run_pass(1'b0, 2, 3, 0, 99, 0, 1'b0, 1'b0);          // reset mid-LOAD

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
